// File: rtl/led_pkg.sv
// led_pkg: shared types, constants and pattern helpers for the LED sequencer.
package led_pkg;

  // Pattern selected by the host configuration.
  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  // Sequencer control state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // 1 s base tick at a 125 MHz clock.
  localparam int          CNT_W_DEFAULT    = 27;
  localparam logic [26:0] TICK_MAX_DEFAULT = 27'd124999999;

  // Pattern loaded when a mode starts (RUN entry or config apply).
  localparam logic [3:0] PAT_INIT_BLINK  = 4'b0000;
  localparam logic [3:0] PAT_INIT_SHIFT  = 4'b0001;
  localparam logic [3:0] PAT_INIT_COUNT  = 4'b0000;
  localparam logic [3:0] PAT_INIT_BOUNCE = 4'b0001;

  // Next pattern plus the bounce direction that goes with it.
  typedef struct packed {
    logic [3:0] pat;
    logic       dir_up;
  } led_step_t;

  function automatic logic [3:0] init_pattern(input mode_e mode);
    case (mode)
      MODE_BLINK:  return PAT_INIT_BLINK;
      MODE_SHIFT:  return PAT_INIT_SHIFT;
      MODE_COUNT:  return PAT_INIT_COUNT;
      default:     return PAT_INIT_BOUNCE;
    endcase
  endfunction

  // One step of the selected pattern. Bounce turns around at either end
  // so each end LED is shown once per sweep.
  function automatic led_step_t advance(input mode_e      mode,
                                        input logic [3:0] pat,
                                        input logic       dir_up);
    led_step_t nxt;
    nxt.dir_up = dir_up;
    case (mode)
      MODE_BLINK: nxt.pat = ~pat;
      MODE_SHIFT: nxt.pat = {pat[2:0], pat[3]};
      MODE_COUNT: nxt.pat = pat + 4'd1;
      default: begin
        if (dir_up) begin
          if (pat == 4'b1000) begin
            nxt.pat    = 4'b0100;
            nxt.dir_up = 1'b0;
          end else begin
            nxt.pat = {pat[2:0], 1'b0};
          end
        end else begin
          if (pat == 4'b0001) begin
            nxt.pat    = 4'b0010;
            nxt.dir_up = 1'b1;
          end else begin
            nxt.pat = {1'b0, pat[3:1]};
          end
        end
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: base prescaler (0..TICK_MAX) followed by a step divider
// that fires every i_period+1 base ticks.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_MAX_DEFAULT)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic [3:0] i_period,
  output logic       o_base_tick,
  output logic       o_step
);

  logic [CNT_W-1:0] r_presc;
  logic [3:0]       r_div;
  logic             w_base_tick;
  logic             w_step;

  // Ticks only count while enabled so a frozen prescaler parked at
  // TICK_MAX does not keep producing strobes.
  assign w_base_tick = i_en && (r_presc == TICK_MAX);
  assign w_step      = w_base_tick && (r_div == i_period);

  // Prescaler and divider: clear wins, otherwise advance only when enabled.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_div   <= '0;
    end else if (i_clr) begin
      r_presc <= '0;
      r_div   <= '0;
    end else if (i_en) begin
      r_presc <= w_base_tick ? '0 : r_presc + CNT_W'(1);
      if (w_step) begin
        r_div <= '0;
      end else if (w_base_tick) begin
        r_div <= r_div + 4'd1;
      end
    end
  end

  assign o_base_tick = w_base_tick;
  assign o_step      = w_step;

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: LED pattern sequencer with IDLE/RUN/HOLD control and a
// valid/ready configuration port (mode + period).
// Optional build macro LED_PWM_DIM_EN adds a dim_duty input and a PWM
// stage that registers LED one extra cycle behind the pattern.
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_MAX_DEFAULT)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       run,
  input  logic       clear,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_mode,
  input  logic [3:0] cfg_period,
`ifdef LED_PWM_DIM_EN
  input  logic [3:0] dim_duty,
`endif
  output logic       cfg_ready,
  output logic       step_pulse,
  output logic [3:0] LED
);

  state_e     r_state;
  mode_e      r_mode;
  mode_e      r_sh_mode;
  logic [3:0] r_period;
  logic [3:0] r_sh_period;
  logic [3:0] r_pat;
  logic       r_dir_up;
  logic       r_pending;
  logic       r_step_pulse;

  logic       w_en;
  logic       w_clr;
  logic       w_base_tick;
  logic       w_step;
  logic       w_xfer;
  mode_e      w_idle_mode;
  led_step_t  w_adv;

  // Counters run only in RUN; they are held at zero in IDLE, on clear and
  // when a pending config is applied from HOLD.
  assign w_en   = (r_state == ST_RUN) && !clear;
  assign w_clr  = clear || (r_state == ST_IDLE) ||
                  ((r_state == ST_HOLD) && r_pending);
  assign w_xfer = cfg_valid && !r_pending;

  // A config applied on the same IDLE edge that starts RUN sets the pattern.
  assign w_idle_mode = r_pending ? r_sh_mode : r_mode;
  assign w_adv       = advance(r_mode, r_pat, r_dir_up);

  led_tick_gen #(
    .CNT_W    (CNT_W),
    .TICK_MAX (TICK_MAX)
  ) u_tick (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_en        (w_en),
    .i_clr       (w_clr),
    .i_period    (r_period),
    .o_base_tick (w_base_tick),
    .o_step      (w_step)
  );

  // Control FSM: config capture/apply, state transitions and pattern update.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_BLINK;
      r_sh_mode    <= MODE_BLINK;
      r_period     <= '0;
      r_sh_period  <= '0;
      r_pat        <= '0;
      r_dir_up     <= 1'b1;
      r_pending    <= 1'b0;
      r_step_pulse <= 1'b0;
    end else begin
      r_step_pulse <= 1'b0;

      // Capture is independent of state; it only happens while not pending,
      // so it never collides with the apply paths below.
      if (w_xfer) begin
        r_sh_mode   <= mode_e'(cfg_mode);
        r_sh_period <= cfg_period;
        r_pending   <= 1'b1;
      end

      if (clear) begin
        // Clear wins over run and over the pattern load of an apply, but a
        // pending config still takes effect rather than being dropped.
        r_state  <= ST_IDLE;
        r_pat    <= '0;
        r_dir_up <= 1'b1;
        if (r_pending) begin
          r_mode    <= r_sh_mode;
          r_period  <= r_sh_period;
          r_pending <= 1'b0;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_pat <= '0;
            if (r_pending) begin
              r_mode    <= r_sh_mode;
              r_period  <= r_sh_period;
              r_pending <= 1'b0;
            end
            if (run) begin
              r_state  <= ST_RUN;
              r_pat    <= init_pattern(w_idle_mode);
              r_dir_up <= 1'b1;
            end
          end

          ST_RUN: begin
            // o_step is already qualified by base_tick; the explicit AND
            // keeps both strobes visibly tied to the pattern update.
            if (w_base_tick && w_step) begin
              r_step_pulse <= 1'b1;
              if (r_pending) begin
                r_mode    <= r_sh_mode;
                r_period  <= r_sh_period;
                r_pending <= 1'b0;
                r_pat     <= init_pattern(r_sh_mode);
                r_dir_up  <= 1'b1;
              end else begin
                r_pat    <= w_adv.pat;
                r_dir_up <= w_adv.dir_up;
              end
            end
            if (!run) begin
              r_state <= ST_HOLD;
            end
          end

          ST_HOLD: begin
            if (r_pending) begin
              r_mode    <= r_sh_mode;
              r_period  <= r_sh_period;
              r_pending <= 1'b0;
              r_pat     <= init_pattern(r_sh_mode);
              r_dir_up  <= 1'b1;
            end
            if (run) begin
              r_state <= ST_RUN;
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign cfg_ready  = ~r_pending;
  assign step_pulse = r_step_pulse;

`ifdef LED_PWM_DIM_EN
  logic [3:0] r_pwm_cnt;
  logic [3:0] r_led;

  // Free-running PWM counter and dimmed, registered LED drive.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pwm_cnt <= '0;
      r_led     <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
      r_led     <= r_pat & {4{r_pwm_cnt <= dim_duty}};
    end
  end

  assign LED = r_led;
`else
  assign LED = r_pat;
`endif

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Sequencer that drives the four board LEDs with selectable patterns at a programmable step rate.
- Owns the 1 s prescaler and the LED register.
- A config handshake (mode + period) comes from a host/button front-end; run/clear inputs start, freeze and stop the sequence.
- Sits directly under the top level in place of the free-running LED toggler.

Parameters:
TICK_MAX, 27'd124999999, terminal count of the base prescaler (1 s at 125 MHz CLK)
CNT_W, 27, prescaler width; must hold TICK_MAX

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-high reset
run  input  1  level: 1 = sequence advances, 0 = freeze
clear  input  1  sync pulse: return to IDLE
cfg_valid  input  1  config request
cfg_mode  input  2  0 BLINK, 1 SHIFT, 2 COUNT, 3 BOUNCE
cfg_period  input  4  base ticks per step minus one
cfg_ready  output  1  config can be accepted
step_pulse  output  1  one-cycle pulse per step
LED  output  4  LED drive, registered

Behaviour:
- Reset (async, immediate): state IDLE; LED=0000; mode=BLINK; period=0; prescaler=0; divider=0; pending=0; cfg_ready=1; step_pulse=0.
- States: IDLE, RUN, HOLD.
  - IDLE: LED=0000; counters held at 0.
  - IDLE->RUN when run=1 and clear=0. On that edge LED loads the initial pattern of the current mode: BLINK 0000, SHIFT 0001, COUNT 0000, BOUNCE 0001.
  - RUN->HOLD when run=0. HOLD freezes the prescaler, divider and LED.
  - HOLD->RUN when run=1. Counting resumes from the frozen values.
  - clear=1 in any state -> IDLE next edge; counters are zeroed. clear has priority over run.
- Prescaler (RUN only): counts 0..TICK_MAX and wraps to 0. base_tick = (prescaler==TICK_MAX).
- Divider: increments on base_tick. step = base_tick && divider==period, which also clears the divider. A period of 0 gives a step on every base_tick.
- Step (RUN):
  - step_pulse=1 for that cycle.
  - LED updates on the same edge: BLINK ~LED; SHIFT rotate left (1000->0001); COUNT +1 mod 16 (1111->0000).
  - BOUNCE ping-pongs 0001,0010,0100,1000,0100,0010,0001,... using an internal direction bit. The direction reverses at 1000 and at 0001; it is reset to "up" on load.
- Config handshake:
  - Transfer when cfg_valid && cfg_ready. The values are captured into shadow registers and pending=1. cfg_ready = ~pending.
  - In IDLE or HOLD: applied the next edge. mode/period update and pending clears. In HOLD, LED loads the new initial pattern and the divider and prescaler are zeroed. In IDLE, LED stays 0000.
  - In RUN: applied at the next step. That step loads the initial pattern instead of advancing, clears pending, and step_pulse still asserts.
  - clear while pending: the pending config is applied on entry to IDLE (not discarded).
- Simultaneous: RST overrides everything. clear beats config apply for the LED value (LED=0000).

Optional Feature:
LED_PWM_DIM_EN.
- Defined:
  - Adds input dim_duty[3:0] and a free-running 4-bit pwm_cnt, reset 0.
  - LED = pattern & {4{pwm_cnt <= dim_duty}}, registered (one extra cycle of latency on LED only). dim_duty=15 gives always on.
  - step_pulse and cfg timing are unchanged.
- Undefined: no port, no counter; LED = pattern register.

Decomposition:
- Package led_pkg: 2-bit mode typedef/enum (BLINK/SHIFT/COUNT/BOUNCE), state typedef, initial-pattern constants per mode, default TICK_MAX.
- Sub-module led_tick_gen: prescaler + divider.
  - Inputs: en, clr, period.
  - Outputs: base_tick, step.

Test Plan:
- TICK_MAX=3, SHIFT, period 0, run=1 -> LED 0001 on RUN entry, then 0010,0100,1000,0001, one step every 4 cycles, step_pulse each step.
- TICK_MAX=3, BOUNCE -> 0001,0010,0100,1000,0100,0010,0001 across 6 consecutive steps.
- TICK_MAX=3, COUNT, period 2 -> step every 12 cycles; after 16 steps LED wraps 1111->0000.
- RUN in SHIFT; cfg_valid with mode=COUNT mid-interval -> cfg_ready drops next cycle; at next step LED=0000 and step_pulse=1; cfg_ready returns to 1.
- run=0 for 10 cycles mid-interval -> LED and counters frozen; on run=1 the next step arrives after exactly the remaining cycles.
- Assert RST asynchronously mid-RUN (between clock edges) -> LED=0000 and cfg_ready=1 before the next edge; after release LED stays 0000 until run=1.
